// File: rtl/mips_multicycle_controller_if.sv
// ============================================================================
// Module   : mips_multicycle_controller_if
// Brief    : Control/status bundle between the multicycle controller and its datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mips_multicycle_controller_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       PCSrc;
  logic             PCEn;
  logic [3:0]       State;
  logic             InstrDone;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, State, InstrDone, IllegalOp,
           InstrCount
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, State, InstrDone, IllegalOp,
           InstrCount
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Brief    : Moore control FSM for a multicycle MIPS core with retire counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  mips_multicycle_controller_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_j     = 6'b000010;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;

  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_done, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluctl   = 3'b000;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_aluctl  = 3'b010;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_aluctl  = 3'b010;
        case (bus.Op)
          c_op_lw, c_op_sw:     w_next = S_MEMADR;
          c_op_rtype:           w_next = S_RTEXE;
          c_op_beq:             w_next = S_BRANCH;
          c_op_addi, c_op_slti: w_next = S_IEXE;
          c_op_j:               w_next = S_JUMP;
          default:              w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = 3'b010;
        w_next    = (bus.Op == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_RTEXE: begin
        w_alusrca = 1'b1;
        w_next    = S_ALUWB;
        case (bus.Funct)
          6'b100000: w_aluctl = 3'b010;
          6'b100010: w_aluctl = 3'b110;
          6'b100100: w_aluctl = 3'b000;
          6'b100101: w_aluctl = 3'b001;
          6'b101010: w_aluctl = 3'b111;
          default: begin
            // Unknown funct abandons the instruction without writeback or retire
            w_aluctl  = 3'b010;
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluctl  = 3'b110;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_done    = 1'b1;
      end
      S_IEXE: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = (bus.Op == c_op_slti) ? 3'b111 : 3'b010;
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Side-effecting strobes are held low for the whole reset window
  assign bus.IRWrite    = w_irwrite  & ~reset;
  assign bus.PCEn       = (w_pcwrite | (w_branch & bus.Zero)) & ~reset;
  assign bus.MemWrite   = w_memwrite & ~reset;
  assign bus.RegWrite   = w_regwrite & ~reset;
  assign bus.InstrDone  = w_done     & ~reset;
  assign bus.IllegalOp  = w_illegal  & ~reset;
  assign bus.IorD       = w_iord;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = w_aluctl;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.State      = r_state;
  assign bus.InstrCount = r_count;

endmodule

`default_nettype wire
